// File: rtl/word_unpacker_pkg.sv
// Shared defaults and width helpers for the word unpacker and its FIFO.
package word_unpacker_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_LANE_W = 8;
   localparam int unsigned DEF_DEPTH  = 4;

   // ceil(log2(n)), never less than 1 so a 1-bit counter still exists
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

   function automatic int unsigned nlanes(input int unsigned data_w, input int unsigned lane_w);
      return data_w / lane_w;
   endfunction

   // Lane counter runs 0..NLANES-1
   function automatic int unsigned lane_cnt_w(input int unsigned data_w, input int unsigned lane_w);
      return clog2_min1(nlanes(data_w, lane_w));
   endfunction

   // FIFO pointers wrap modulo DEPTH (power of two)
   function automatic int unsigned ptr_w(input int unsigned depth);
      return clog2_min1(depth);
   endfunction

   // Occupancy must represent 0..DEPTH inclusive
   function automatic int unsigned fifo_cnt_w(input int unsigned depth);
      return ptr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/word_unpacker_sync_fifo.sv
// DEPTH-entry synchronous FIFO; push is ignored when full, pop when empty.
module sync_fifo
   import word_unpacker_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_W,
   parameter int unsigned DEPTH = DEF_DEPTH,
   localparam int unsigned PTR_W = ptr_w(DEPTH),
   localparam int unsigned CNT_W = fifo_cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/word_unpacker.sv
// Buffers DATA_W-bit words and streams them out one LANE_W-bit lane per transfer.
module word_unpacker
   import word_unpacker_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned LANE_W    = DEF_LANE_W,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic [LANE_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready_out,
   output logic              last_out,
   output logic              overflow
);

   localparam int unsigned NLANES = nlanes(DATA_W, LANE_W);
   localparam int unsigned LCNT_W = lane_cnt_w(DATA_W, LANE_W);
   localparam int unsigned FCNT_W = fifo_cnt_w(DEPTH);

   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic [FCNT_W-1:0] unused_fifo_count;
   logic [LCNT_W-1:0] lane_cnt;
   logic [LCNT_W-1:0] lane_idx;
   logic              lane_last;
   logic              lane_xfer;
   logic              word_pop;

   // Occupancy is visible through full/empty; the raw count is not needed here
   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_L (reset_L),
      .push    (valid_in),
      .pop     (word_pop),
      .din     (data_in),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .count   (unused_fifo_count)
   );

   assign ready_in  = !full;
   assign valid_out = !empty;
   assign lane_last = (lane_cnt == LCNT_W'(NLANES - 1));
   assign lane_xfer = valid_out && ready_out;
   assign word_pop  = lane_xfer && lane_last;
   assign last_out  = lane_last && valid_out;
   assign lane_idx  = (MSB_FIRST != 0) ? (LCNT_W'(NLANES - 1) - lane_cnt) : lane_cnt;

   // Lane mux from the head word; forced to zero while nothing is buffered
   always_comb begin
      data_out = '0;
      if (valid_out) begin
         for (int unsigned i = 0; i < NLANES; i++) begin
            if (LCNT_W'(i) == lane_idx) data_out = head[i*LANE_W +: LANE_W];
         end
      end
   end

   // Lane position advances per transfer, wrapping together with the head pop; sticky overflow
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         lane_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (lane_xfer) lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
         if (valid_in && !ready_in) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench: three word_unpacker configurations share one stimulus
// stream and are compared every cycle against a word-queue model.
module tb_word_unpacker;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned NL    = 4;

   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic [31:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_out = 1'b0;

   logic       ready_in_a, valid_out_a, last_out_a, overflow_a;
   logic [7:0] data_out_a;
   logic       ready_in_b, valid_out_b, last_out_b, overflow_b;
   logic [7:0] data_out_b;
   logic       ready_in_c, valid_out_c, last_out_c, overflow_c;
   logic [3:0] data_out_c;

   always #5 clk = ~clk;

   word_unpacker #(.DATA_W(32), .LANE_W(8), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_in_a), .data_out(data_out_a), .valid_out(valid_out_a),
      .ready_out(ready_out), .last_out(last_out_a), .overflow(overflow_a));

   word_unpacker #(.DATA_W(32), .LANE_W(8), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_in_b), .data_out(data_out_b), .valid_out(valid_out_b),
      .ready_out(ready_out), .last_out(last_out_b), .overflow(overflow_b));

   word_unpacker #(.DATA_W(16), .LANE_W(4), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_c (
      .clk(clk), .reset_L(reset_L), .data_in(data_in[15:0]), .valid_in(valid_in),
      .ready_in(ready_in_c), .data_out(data_out_c), .valid_out(valid_out_c),
      .ready_out(ready_out), .last_out(last_out_c), .overflow(overflow_c));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] lane8(input logic [31:0] w, input int idx);
      return 8'(w >> (idx * 8));
   endfunction

   function automatic logic [3:0] lane4(input logic [31:0] w, input int idx);
      return 4'(w[15:0] >> (idx * 4));
   endfunction

   // Model: queue of accepted words plus position within the head word
   logic [31:0] mq[$];
   int          m_pos = 0;
   logic        m_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         mq.delete();
         m_pos <= 0;
         m_ovf <= 1'b0;
      end else begin
         if (valid_in && mq.size() >= DEPTH) m_ovf <= 1'b1;
         if (mq.size() != 0 && ready_out) begin
            if (m_pos == NL - 1) begin
               m_pos <= 0;
               void'(mq.pop_front());
            end else begin
               m_pos <= m_pos + 1;
            end
         end
         if (valid_in && mq.size() < DEPTH) mq.push_back(data_in);
      end
   end

   // Transfer logs: {last, lane}
   logic [8:0] log_a[$];
   logic [8:0] log_b[$];
   logic [4:0] log_c[$];
   int         stamp_c[$];

   // Compare process: outputs against the model every cycle
   always @(negedge clk) begin
      if (!reset_L) begin
         check("rst_valid_a", valid_out_a, 0);
         check("rst_valid_c", valid_out_c, 0);
         check("rst_ready_a", ready_in_a, 1);
         check("rst_ready_c", ready_in_c, 1);
         check("rst_last_a", last_out_a, 0);
         check("rst_data_a", data_out_a, 0);
         check("rst_data_b", data_out_b, 0);
         check("rst_data_c", data_out_c, 0);
         check("rst_ovf_a", overflow_a, 0);
         check("rst_ovf_c", overflow_c, 0);
      end else begin
         check("valid_a", valid_out_a, mq.size() != 0);
         check("valid_b", valid_out_b, mq.size() != 0);
         check("valid_c", valid_out_c, mq.size() != 0);
         check("ready_in_a", ready_in_a, mq.size() < DEPTH);
         check("ready_in_b", ready_in_b, mq.size() < DEPTH);
         check("ready_in_c", ready_in_c, mq.size() < DEPTH);
         check("ovf_a", overflow_a, m_ovf);
         check("ovf_b", overflow_b, m_ovf);
         check("ovf_c", overflow_c, m_ovf);
         if (mq.size() != 0) begin
            check("data_a", data_out_a, lane8(mq[0], NL - 1 - m_pos));
            check("data_b", data_out_b, lane8(mq[0], m_pos));
            check("data_c", data_out_c, lane4(mq[0], NL - 1 - m_pos));
            check("last_a", last_out_a, m_pos == NL - 1);
            check("last_b", last_out_b, m_pos == NL - 1);
            check("last_c", last_out_c, m_pos == NL - 1);
         end else begin
            check("idle_last_a", last_out_a, 0);
         end
         if (valid_out_a && ready_out) begin
            log_a.push_back({last_out_a, data_out_a});
            log_b.push_back({last_out_b, data_out_b});
         end
         if (valid_out_c && ready_out) begin
            log_c.push_back({last_out_c, data_out_c});
            stamp_c.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      log_a.delete();
      log_b.delete();
      log_c.delete();
      stamp_c.delete();
   endtask

   logic [8:0] exp_a1[4] = '{9'h02E, 9'h09F, 9'h013, 9'h105};
   logic [8:0] exp_b1[4] = '{9'h005, 9'h013, 9'h09F, 9'h12E};
   logic [4:0] exp_c2[8] = '{5'h0A, 5'h0B, 5'h0C, 5'h1D, 5'h01, 5'h02, 5'h03, 5'h14};
   logic [31:0] burst[5] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'hDEADBEEF};
   logic [8:0] exp_a6[4] = '{9'h011, 9'h022, 9'h033, 9'h144};

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_L = 1'b1;
      step();

      // Single word, MSB-first and LSB-first orderings
      clear_logs();
      ready_out = 1'b1;
      valid_in  = 1'b1;
      data_in   = 32'h2E9F1305;
      step();
      valid_in = 1'b0;
      repeat (6) step();
      check("p1_count_a", log_a.size(), 4);
      for (int i = 0; i < 4 && i < log_a.size(); i++) begin
         check($sformatf("p1_lane_a%0d", i), log_a[i], exp_a1[i]);
         check($sformatf("p1_lane_b%0d", i), log_b[i], exp_b1[i]);
      end

      // Two 16-bit words back to back on the narrow instance, no idle cycle
      clear_logs();
      valid_in = 1'b1;
      data_in  = 32'h0000ABCD;
      step();
      data_in  = 32'h00001234;
      step();
      valid_in = 1'b0;
      repeat (10) step();
      check("p2_count_c", log_c.size(), 8);
      for (int i = 0; i < 8 && i < log_c.size(); i++) begin
         check($sformatf("p2_lane_c%0d", i), log_c[i], exp_c2[i]);
         check($sformatf("p2_gap_c%0d", i), stamp_c[i] - stamp_c[0], i);
      end

      // Fill with consumer stalled: fifth word dropped, overflow sticks
      clear_logs();
      ready_out = 1'b0;
      valid_in  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = burst[i];
         step();
      end
      valid_in = 1'b0;
      step();
      check("p3_ready_in_low", ready_in_a, 0);
      check("p3_overflow_set", overflow_a, 1);
      ready_out = 1'b1;
      repeat (20) step();
      check("p3_count_a", log_a.size(), 16);
      for (int i = 0; i < 16 && i < log_a.size(); i++)
         check($sformatf("p3_lane_a%0d", i), log_a[i], {(i % 4) == 3, 8'(i + 1)});

      // Consumer toggling: every lane held, none skipped or repeated
      clear_logs();
      valid_in = 1'b1;
      data_in  = 32'h2E9F1305;
      step();
      valid_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         ready_out = (i % 2 == 0);
         step();
      end
      ready_out = 1'b1;
      repeat (3) step();
      check("p4_count_a", log_a.size(), 4);
      for (int i = 0; i < 4 && i < log_a.size(); i++)
         check($sformatf("p4_lane_a%0d", i), log_a[i], exp_a1[i]);

      // Reset after two lanes of a word
      clear_logs();
      valid_in = 1'b1;
      data_in  = 32'h2E9F1305;
      step();
      valid_in = 1'b0;
      step();
      step();
      check("p5_lanes_before_rst", log_a.size(), 2);
      reset_L = 1'b0;
      step();
      check("p5_rst_valid", valid_out_a, 0);
      check("p5_rst_ovf", overflow_a, 0);
      step();
      reset_L = 1'b1;
      clear_logs();
      step();
      valid_in = 1'b1;
      data_in  = 32'h11223344;
      step();
      valid_in = 1'b0;
      repeat (6) step();
      check("p5_count_a", log_a.size(), 4);
      for (int i = 0; i < 4 && i < log_a.size(); i++)
         check($sformatf("p5_lane_a%0d", i), log_a[i], exp_a6[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, input word width in bits.
REQ-002 The block SHALL have parameter LANE_W, default 8, output lane width; DATA_W SHALL be an integer multiple of LANE_W, with NLANES = DATA_W/LANE_W >= 2.
REQ-003 The block SHALL have parameter DEPTH, default 4, input word buffer depth; DEPTH SHALL be a power of two and >= 2.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1; 1 = lane NLANES-1 (top bits) is emitted first, 0 = lane 0 is emitted first.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_L  input  1  asynchronous, active-low reset.
REQ-007 data_in  input  DATA_W  input word.
REQ-008 valid_in  input  1  data_in is valid this cycle.
REQ-009 ready_in  output  1  buffer can accept a word; a transfer occurs when valid_in and ready_in are both 1.
REQ-010 data_out  output  LANE_W  current lane.
REQ-011 valid_out  output  1  data_out is valid.
REQ-012 ready_out  input  1  consumer accepts; a lane transfer occurs when valid_out and ready_out are both 1.
REQ-013 last_out  output  1  data_out is the final lane of its word.
REQ-014 overflow  output  1  sticky: valid_in was high while ready_in was low.

Function
- REQ-015 Input words SHALL be written into a DEPTH-entry FIFO (write pointer, read pointer, count of width log2(DEPTH)+1); ready_in = (count != DEPTH), registered-state-derived only, no combinational path from ready_out.
- REQ-016 Lane selection SHALL use a lane counter 0..NLANES-1; emitted lane index = NLANES-1-cnt when MSB_FIRST=1, else cnt.
- REQ-017 valid_out = (count != 0); data_out/last_out SHALL be combinational from the FIFO head entry and the lane counter.
- REQ-018 On each lane transfer the lane counter SHALL increment; at cnt = NLANES-1 it SHALL wrap to 0 and pop the head word in the same cycle; last_out = (cnt == NLANES-1) && valid_out.
- REQ-019 Latency: a word written at edge k SHALL present its first lane at valid_out after edge k (one cycle), if the FIFO was empty.
- REQ-020 Throughput: with ready_out held 1, one lane per cycle and no bubble between consecutive words.
- REQ-021 Simultaneous push and pop in one cycle SHALL leave count unchanged; push is permitted when full only if a pop occurs in the same cycle? No: push is accepted only when ready_in = 1 (full blocks push even with a concurrent pop).
- REQ-022 ready_out low SHALL hold data_out, last_out and the lane counter stable.
- REQ-023 valid_in with ready_in = 0 SHALL discard the word and set overflow; overflow clears only on reset.
- REQ-024 Pointers SHALL wrap modulo DEPTH.

Reset
- REQ-025 While reset_L = 0: count = 0, pointers = 0, lane counter = 0, overflow = 0; hence valid_out = 0, last_out = 0, ready_in = 1; data_out = 0.
- REQ-026 Reset asserted mid-word SHALL discard all buffered words and the partial lane position; the first lane after release SHALL come from the first word accepted after release.

Structure
- REQ-027 A shared package SHALL hold the default DATA_W/LANE_W/DEPTH constants and a function computing NLANES and the counter widths.
- REQ-028 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated once.

Verification
- REQ-029 Defaults, MSB_FIRST=1, push 0x2E9F1305 with ready_out=1 -> lanes 0x2E, 0x9F, 0x13, 0x05 on consecutive cycles, last_out with 0x05.
- REQ-030 MSB_FIRST=0, same word -> 0x05, 0x13, 0x9F, 0x2E; last_out with 0x2E.
- REQ-031 Push 5 words back-to-back with ready_out=0 -> ready_in low after 4th, 5th word dropped, overflow = 1; then ready_out=1 -> exactly 16 lanes of words 1-4 in order.
- REQ-032 ready_out toggling 1,0,1,0 on word 0x2E9F1305 -> each lane held while ready_out=0, no lane skipped or repeated.
- REQ-033 reset_L pulsed low after 2 lanes of a word -> valid_out=0, overflow=0 during reset; next word 0x11223344 emits 0x11 first.
- REQ-034 DATA_W=16, LANE_W=4, continuous words 0xABCD, 0x1234 -> A,B,C,D,1,2,3,4 with no idle cycle.
